wb_ifetch_prefetch: RTL and testbench

Instruction prefetch buffer between the instruction Wishbone master of `custom_riscv_core` (`iwb_*`) and the instruction memory slave. It fetches sequential words ahead of the core into a small FIFO and answers hits with one-cycle latency. A non-sequential request (branch, jump, trap) flushes the buffer and restarts fetching at the requested address. Memory errors are carried through the buffer and reported to the core in order.

---
 rtl/wb_ifetch_prefetch.sv | 152 +++++++++++++++
 tb/tb_wb_ifetch_prefetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ifetch_prefetch.sv
// wb_ifetch_prefetch
//   Instruction prefetch buffer between a core's instruction Wishbone master
//   and the instruction memory slave. Sequential words are fetched ahead into
//   a small FIFO. Requests that match the FIFO head are answered one cycle
//   later. Any other request flushes the FIFO and restarts fetching at the
//   requested address. Memory errors travel through the FIFO in order.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   s_adr_i/s_cyc_i/s_stb_i  core fetch request (s_adr_i[1:0] ignored)
//   s_dat_o/s_ack_o/s_err_o  core response, each response lasts one cycle
//   m_adr_o/m_cyc_o/m_stb_o  memory fetch request, one transaction at a time
//   m_dat_i/m_ack_i/m_err_i  memory response
module wb_ifetch_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_adr_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [31:0] m_adr_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t          state, state_nx;
    logic [31:0]     fifo_dat [DEPTH];
    logic [DEPTH-1:0] fifo_err;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [29:0]     head_adr, fetch_adr;   // word addresses
    logic            discard, halt;

    logic busy, req, hit, wait_word, miss, done, push, can_fetch, launch;
    logic [AW+1:0] occupancy;
    logic unused_adr_lsb;

    assign unused_adr_lsb = ^s_adr_i[1:0];

    assign busy      = (state == REQ);
    assign req       = s_cyc_i & s_stb_i & ~s_ack_o & ~s_err_o;
    assign hit       = req && (count != '0) && (s_adr_i[31:2] == head_adr);
    assign wait_word = req && (count == '0) && (s_adr_i[31:2] == fetch_adr) && !discard;
    assign miss      = req && !hit && !wait_word;
    assign done      = busy && (m_ack_i || m_err_i);
    // A flush on the same edge wins over the push: that word is from the old stream.
    assign push      = done && !discard && !miss;
    assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, busy};
    assign can_fetch = (occupancy < DEPTH_W) && !halt;

    assign m_cyc_o = busy;
    assign m_stb_o = busy;

    // A miss launches the new target straight away when no transaction is
    // outstanding, so the first word of the new stream is not delayed by a
    // cycle. GAP re-launches directly to sustain one word per three cycles.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (miss || can_fetch) begin
                    state_nx = REQ;
                    launch   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: if (done) state_nx = GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_dat[wr_ptr] <= m_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_adr_o   <= '0;
            fifo_err  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_adr  <= RESET_ADDR[31:2];
            fetch_adr <= RESET_ADDR[31:2];
            discard   <= 1'b0;
            halt      <= 1'b0;
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_dat_o   <= '0;
        end else begin
            state <= state_nx;

            // m_adr_o only changes when a transaction starts, so it is stable
            // for the whole strobe even if a miss retargets fetch_adr.
            if (launch)
                m_adr_o <= {(miss ? s_adr_i[31:2] : fetch_adr), 2'b00};
            else if (done)
                m_adr_o <= '0;

            // The outstanding result belongs to the old stream unless it
            // completes on this very edge.
            if (done)
                discard <= 1'b0;
            else if (miss && busy)
                discard <= 1'b1;

            s_ack_o <= hit && !fifo_err[rd_ptr];
            s_err_o <= hit &&  fifo_err[rd_ptr];
            if (hit) s_dat_o <= fifo_dat[rd_ptr];

            if (miss) begin
                count     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                head_adr  <= s_adr_i[31:2];
                fetch_adr <= s_adr_i[31:2];
                halt      <= 1'b0;
            end else begin
                if (push) begin
                    fifo_err[wr_ptr] <= m_err_i;
                    wr_ptr    <= wr_ptr + 1'b1;
                    fetch_adr <= fetch_adr + 30'd1;
                    if (m_err_i) halt <= 1'b1;
                end
                if (hit) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    head_adr <= head_adr + 30'd1;
                end
                case ({push, hit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wb_ifetch_prefetch.sv
// Directed bench for wb_ifetch_prefetch: cold start, hits, branch, full
// buffer, flush with a stalled fetch, error propagation, reset mid-fetch.
module tb_wb_ifetch_prefetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_adr_i;
    logic        s_cyc_i, s_stb_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o, s_err_o;
    logic [31:0] m_adr_o;
    logic        m_cyc_o, m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i, m_err_i;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] err_adr  = 32'hFFFF_FFFF;
    logic [31:0] slow_adr = 32'hFFFF_FFFF;

    wb_ifetch_prefetch #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_adr_i(s_adr_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .m_adr_o(m_adr_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h00a0_0093;
            32'h04:  return 32'h00a0_0113;
            32'h08:  return 32'h0020_8663;
            32'h14:  return 32'h04d0_0293;
            default: return 32'h1300_0000 | a;
        endcase
    endfunction

    // Memory slave with registered ack; slow_adr takes three extra cycles.
    int wcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack_i <= 1'b0; m_err_i <= 1'b0; m_dat_i <= '0; wcnt <= 0;
        end else begin
            m_ack_i <= 1'b0; m_err_i <= 1'b0;
            if (m_stb_o && !m_ack_i && !m_err_i) begin
                if (m_adr_o == slow_adr && wcnt < 3) wcnt <= wcnt + 1;
                else begin
                    wcnt    <= 0;
                    m_dat_i <= memw(m_adr_o);
                    if (m_adr_o == err_adr) m_err_i <= 1'b1;
                    else                    m_ack_i <= 1'b1;
                end
            end
        end
    end

    // Strobe-rise log since the last reset.
    int          nrise, cyc;
    logic        prev_stb;
    logic [31:0] rise_adr [8];
    int          rise_cyc [8];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrise <= 0; cyc <= 0; prev_stb <= 1'b0;
        end else begin
            cyc      <= cyc + 1;
            prev_stb <= m_stb_o;
            if (m_stb_o && !prev_stb) begin
                if (nrise < 8) begin
                    rise_adr[nrise] <= m_adr_o;
                    rise_cyc[nrise] <= cyc;
                end
                nrise <= nrise + 1;
            end
        end
    end

    // Responses must be exclusive and never back-to-back.
    logic prev_resp = 1'b0;
    logic bad_resp  = 1'b0;
    always @(posedge clk) begin
        prev_resp <= s_ack_o | s_err_o;
        if ((s_ack_o && s_err_o) || ((s_ack_o || s_err_o) && prev_resp)) bad_resp <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one core fetch and wait for its response.
    // resp = {err, ack}; adr1 = memory address strobed in the first cycle after the request.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat, output logic [31:0] adr1);
        logic got;
        got = 1'b0; d = '0; resp = 2'b00; lat = 0; adr1 = 32'hDEAD_BEEF;
        s_adr_i = a; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (lat == 1 && m_stb_o) adr1 = m_adr_o;
            if (s_ack_o || s_err_o) begin
                got = 1'b1; d = s_dat_o; resp = {s_err_o, s_ack_o};
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        if (!got) chk("fetch_timeout", {31'b0, s_ack_o | s_err_o}, 32'd1);
    endtask

    logic [31:0] d, a1, first_new;
    logic [1:0]  r;
    int          lat, n0;
    logic        seen;

    initial begin
        rst_n = 1'b0; s_adr_i = '0; s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (3) tick();
        chk("rst_m_stb", {31'b0, m_stb_o}, 32'd0);
        chk("rst_s_ack", {31'b0, s_ack_o}, 32'd0);
        chk("rst_m_adr", m_adr_o, 32'd0);
        chk("rst_count", 32'(dut.count), 32'd0);
        rst_n = 1'b1;

        // Cold start / full buffer
        repeat (16) tick();
        chk("full_count", 32'(dut.count), 32'd4);
        chk("full_stb", {31'b0, m_stb_o}, 32'd0);
        chk("full_ntxn", nrise, 4);
        chk("full_adr0", rise_adr[0], 32'h00);
        chk("full_adr3", rise_adr[3], 32'h0C);
        chk("full_gap01", rise_cyc[1] - rise_cyc[0], 3);
        chk("full_gap23", rise_cyc[3] - rise_cyc[2], 3);
        repeat (5) tick();
        chk("full_quiet", nrise, 4);

        fetch(32'h00, d, r, lat, a1);
        chk("hit0_dat", d, 32'h00a0_0093);
        chk("hit0_resp", {30'b0, r}, 32'b01);
        chk("hit0_lat", lat, 1);
        fetch(32'h04, d, r, lat, a1);
        chk("hit4_dat", d, 32'h00a0_0113);
        fetch(32'h08, d, r, lat, a1);
        chk("hit8_dat", d, 32'h0020_8663);

        // Branch to 0x14 with the buffer full and memory idle
        repeat (15) tick();
        fetch(32'h14, d, r, lat, a1);
        chk("br_adr", a1, 32'h14);
        chk("br_lat", lat, 4);
        chk("br_dat", d, 32'h04d0_0293);

        // Flush while the fetch of 0x10 is stalled
        slow_adr = 32'h10;
        fetch(32'h08, d, r, lat, a1);
        chk("fl_pre_dat", d, memw(32'h08));
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (m_stb_o && m_adr_o == 32'h10) seen = 1'b1;
        end
        chk("fl_saw_0x10", {31'b0, seen}, 32'd1);
        s_adr_i = 32'h40; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        tick();
        chk("fl_adr_hold", m_adr_o, 32'h10);
        first_new = 32'hDEAD_BEEF; seen = 1'b0; d = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (m_stb_o && m_adr_o != 32'h10 && first_new == 32'hDEAD_BEEF) first_new = m_adr_o;
            if (s_ack_o || s_err_o) begin seen = 1'b1; d = s_dat_o; end
            else tick();
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        chk("fl_next_adr", first_new, 32'h40);
        chk("fl_dat", d, memw(32'h40));
        slow_adr = 32'hFFFF_FFFF;

        // Error at 0x0C
        err_adr = 32'h0C;
        fetch(32'h00, d, r, lat, a1);
        chk("er_dat0", d, 32'h00a0_0093);
        fetch(32'h04, d, r, lat, a1);
        fetch(32'h08, d, r, lat, a1);
        chk("er_dat8", d, 32'h0020_8663);
        fetch(32'h0C, d, r, lat, a1);
        chk("er_resp", {30'b0, r}, 32'b10);
        n0 = nrise;
        repeat (10) tick();
        chk("er_halt", nrise - n0, 0);
        chk("er_stb", {31'b0, m_stb_o}, 32'd0);
        err_adr = 32'hFFFF_FFFF;
        fetch(32'h00, d, r, lat, a1);
        chk("er_resume_resp", {30'b0, r}, 32'b01);
        chk("er_resume_dat", d, 32'h00a0_0093);

        // Reset during a fetch
        fetch(32'h04, d, r, lat, a1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (m_stb_o && m_adr_o != 32'h0) seen = 1'b1;
            else tick();
        end
        chk("rm_in_req", {31'b0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_stb", {31'b0, m_stb_o}, 32'd0);
        chk("rm_ack", {31'b0, s_ack_o}, 32'd0);
        chk("rm_count", 32'(dut.count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (m_stb_o) seen = 1'b1;
        end
        chk("rm_restart", {31'b0, seen}, 32'd1);
        chk("rm_adr", m_adr_o, 32'h0);

        repeat (3) tick();
        chk("resp_excl", {31'b0, bad_resp}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
